oldland_dbus_arb: RTL and testbench

- Shares the single data-memory bus between two masters: the CPU data port and the debug unit's memory master port.
- The debug master issues a one-cycle mem_access pulse with width 8/16/32 and then waits for mem_compl. The CPU holds d_access until it sees an ack.
- The block captures the debug pulse, arbitrates (debug wins), steers byte lanes for debug accesses, and aborts hung debug accesses with a timeout.
- Sits between oldland_cpu / oldland_debug and the top-level memory interconnect.

---
 rtl/oldland_dbus_arb_pkg.sv | 16 +
 rtl/oldland_dbus_lane.sv | 38 +++
 rtl/oldland_dbus_arb.sv | 157 +++++++++++++++
 tb/tb_oldland_dbus_arb.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oldland_dbus_arb_pkg.sv
// Shared definitions for the Oldland data-bus arbiter and lane steering logic.
package oldland_dbus_arb_pkg;

    localparam logic [1:0] BUS_WIDTH_8  = 2'b00;
    localparam logic [1:0] BUS_WIDTH_16 = 2'b01;
    localparam logic [1:0] BUS_WIDTH_32 = 2'b10;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CPU  = 2'd1,
        ARB_DBG  = 2'd2
    } arb_state_t;

    localparam int TIMEOUT_W = 16;

endpackage

// File: rtl/oldland_dbus_lane.sv
// Byte-lane steering between a right-justified 8/16/32-bit value and the 32-bit bus.
module oldland_dbus_lane
    import oldland_dbus_arb_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  width,
    input  logic [31:0] wr_val,
    input  logic [31:0] m_data,
    output logic [3:0]  bytesel,
    output logic [31:0] wr_val_out,
    output logic [31:0] rd_val
);

    logic [31:0] byte_shifted;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        bytesel      = 4'b1111;
        wr_val_out   = wr_val;
        rd_val       = m_data;
        byte_shifted = m_data >> {addr, 3'b000};

        case (width)
            BUS_WIDTH_8: begin
                bytesel    = 4'b0001 << addr;
                wr_val_out = {4{wr_val[7:0]}};
                rd_val     = {24'b0, byte_shifted[7:0]};
            end
            BUS_WIDTH_16: begin
                bytesel    = addr[1] ? 4'b1100 : 4'b0011;
                wr_val_out = {2{wr_val[15:0]}};
                rd_val     = {16'b0, addr[1] ? m_data[31:16] : m_data[15:0]};
            end
            default: ;  // word, and the unused 2'b11 encoding, pass straight through
        endcase
    end

endmodule

// File: rtl/oldland_dbus_arb.sv
// Data-bus arbiter: CPU and debug masters share one bus, debug wins, debug
// accesses are lane-steered and aborted if the slave never responds.
module oldland_dbus_arb
    import oldland_dbus_arb_pkg::*;
#(
    parameter int unsigned timeout_cycles = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] c_addr,
    input  logic [3:0]  c_bytesel,
    input  logic        c_wr_en,
    input  logic [31:0] c_wr_val,
    input  logic        c_access,
    output logic [31:0] c_data,
    output logic        c_ack,
    output logic        c_error,
    input  logic [31:0] g_addr,
    input  logic [1:0]  g_width,
    input  logic        g_wr_en,
    input  logic [31:0] g_wr_val,
    input  logic        g_access,
    output logic [31:0] g_rd_val,
    output logic        g_compl,
    output logic        g_error,
    output logic [31:0] m_addr,
    output logic [3:0]  m_bytesel,
    output logic        m_wr_en,
    output logic [31:0] m_wr_val,
    output logic        m_access,
    input  logic [31:0] m_data,
    input  logic        m_ack,
    input  logic        m_error
);

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(timeout_cycles - 1);

    arb_state_t           state_q, state_d;
    logic                 pending_q, pending_d;
    logic [31:0]          g_addr_q, g_addr_d;
    logic [1:0]           g_width_q, g_width_d;
    logic                 g_wr_en_q, g_wr_en_d;
    logic [31:0]          g_wr_val_q, g_wr_val_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    logic [3:0]  lane_bytesel;
    logic [31:0] lane_wr_val;
    logic [31:0] lane_rd_val;

    oldland_dbus_lane u_lane (
        .addr       (g_addr_q[1:0]),
        .width      (g_width_q),
        .wr_val     (g_wr_val_q),
        .m_data     (m_data),
        .bytesel    (lane_bytesel),
        .wr_val_out (lane_wr_val),
        .rd_val     (lane_rd_val)
    );

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        g_addr_d   = g_addr_q;
        g_width_d  = g_width_q;
        g_wr_en_d  = g_wr_en_q;
        g_wr_val_d = g_wr_val_q;
        cnt_d      = cnt_q;

        c_data    = '0;
        c_ack     = 1'b0;
        c_error   = 1'b0;
        g_rd_val  = '0;
        g_compl   = 1'b0;
        g_error   = 1'b0;
        m_addr    = '0;
        m_bytesel = '0;
        m_wr_en   = 1'b0;
        m_wr_val  = '0;
        m_access  = 1'b0;

        // The debug pulse is only accepted while no debug transfer is outstanding.
        if (g_access && !pending_q && state_q != ARB_DBG) begin
            g_addr_d   = g_addr;
            g_width_d  = g_width;
            g_wr_en_d  = g_wr_en;
            g_wr_val_d = g_wr_val;
            pending_d  = 1'b1;
        end

        case (state_q)
            ARB_IDLE: begin
                if (pending_q) begin
                    state_d = ARB_DBG;
                    cnt_d   = '0;
                end else if (c_access) begin
                    state_d = ARB_CPU;
                end
            end
            ARB_CPU: begin
                m_addr    = c_addr & ~32'd3;
                m_bytesel = c_bytesel;
                m_wr_en   = c_wr_en;
                m_wr_val  = c_wr_val;
                m_access  = 1'b1;
                c_data    = m_data;
                c_ack     = m_ack;
                c_error   = m_error;
                if (m_ack || m_error) state_d = ARB_IDLE;
            end
            ARB_DBG: begin
                m_addr    = g_addr_q & ~32'd3;
                m_bytesel = lane_bytesel;
                m_wr_en   = g_wr_en_q;
                m_wr_val  = lane_wr_val;
                m_access  = 1'b1;
                // A slave response in the timeout cycle still counts as a normal completion.
                if (m_ack || m_error) begin
                    state_d   = ARB_IDLE;
                    pending_d = 1'b0;
                    g_compl   = 1'b1;
                    g_error   = m_error;
                    g_rd_val  = lane_rd_val;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = ARB_IDLE;
                    pending_d = 1'b0;
                    g_compl   = 1'b1;
                    g_error   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            pending_q  <= 1'b0;
            cnt_q      <= '0;
            g_addr_q   <= '0;
            g_width_q  <= '0;
            g_wr_en_q  <= 1'b0;
            g_wr_val_q <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            cnt_q      <= cnt_d;
            g_addr_q   <= g_addr_d;
            g_width_q  <= g_width_d;
            g_wr_en_q  <= g_wr_en_d;
            g_wr_val_q <= g_wr_val_d;
        end
    end

endmodule

// File: tb/tb_oldland_dbus_arb.sv
// Directed bench for oldland_dbus_arb with a short timeout so abort paths are cheap to reach.
module tb_oldland_dbus_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] c_addr;
    logic [3:0]  c_bytesel;
    logic        c_wr_en;
    logic [31:0] c_wr_val;
    logic        c_access;
    logic [31:0] c_data;
    logic        c_ack;
    logic        c_error;
    logic [31:0] g_addr;
    logic [1:0]  g_width;
    logic        g_wr_en;
    logic [31:0] g_wr_val;
    logic        g_access;
    logic [31:0] g_rd_val;
    logic        g_compl;
    logic        g_error;
    logic [31:0] m_addr;
    logic [3:0]  m_bytesel;
    logic        m_wr_en;
    logic [31:0] m_wr_val;
    logic        m_access;
    logic [31:0] m_data;
    logic        m_ack;
    logic        m_error;

    int checks   = 0;
    int failures = 0;

    oldland_dbus_arb #(.timeout_cycles(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .c_addr    (c_addr),
        .c_bytesel (c_bytesel),
        .c_wr_en   (c_wr_en),
        .c_wr_val  (c_wr_val),
        .c_access  (c_access),
        .c_data    (c_data),
        .c_ack     (c_ack),
        .c_error   (c_error),
        .g_addr    (g_addr),
        .g_width   (g_width),
        .g_wr_en   (g_wr_en),
        .g_wr_val  (g_wr_val),
        .g_access  (g_access),
        .g_rd_val  (g_rd_val),
        .g_compl   (g_compl),
        .g_error   (g_error),
        .m_addr    (m_addr),
        .m_bytesel (m_bytesel),
        .m_wr_en   (m_wr_en),
        .m_wr_val  (m_wr_val),
        .m_access  (m_access),
        .m_data    (m_data),
        .m_ack     (m_ack),
        .m_error   (m_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Each cycle: tick to just after the edge, drive inputs, settle, then sample.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic dbg_pulse(input logic [31:0] addr, input logic [1:0] width,
                             input logic wr, input logic [31:0] val);
        g_addr   = addr;
        g_width  = width;
        g_wr_en  = wr;
        g_wr_val = val;
        g_access = 1'b1;
        tick();
        g_access = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the sequence finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        c_addr = '0; c_bytesel = '0; c_wr_en = 1'b0; c_wr_val = '0; c_access = 1'b0;
        g_addr = '0; g_width = '0; g_wr_en = 1'b0; g_wr_val = '0; g_access = 1'b0;
        m_data = '0; m_ack = 1'b0; m_error = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        settle();
        check("rst_m_access", m_access, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_c_ack", c_ack, 0);
        check("rst_g_compl", g_compl, 0);

        // CPU-only read, ack on the second bus cycle
        c_access = 1'b1; c_addr = 32'h100; c_bytesel = 4'b1111; m_data = 32'h12345678;
        settle();
        check("cpu_idle_m_access", m_access, 0);
        tick();
        settle();
        check("cpu_c1_m_access", m_access, 1);
        check("cpu_c1_m_addr", m_addr, 32'h100);
        check("cpu_c1_m_bytesel", m_bytesel, 4'b1111);
        check("cpu_c1_c_ack", c_ack, 0);
        tick();
        m_ack = 1'b1;
        settle();
        check("cpu_c2_m_access", m_access, 1);
        check("cpu_c2_c_ack", c_ack, 1);
        check("cpu_c2_c_data", c_data, 32'h12345678);
        check("cpu_c2_g_compl", g_compl, 0);
        tick();
        m_ack = 1'b0; c_access = 1'b0;
        settle();
        check("cpu_done_m_access", m_access, 0);
        check("cpu_done_c_ack", c_ack, 0);

        // Debug half read from the upper half-word
        dbg_pulse(32'h202, 2'b01, 1'b0, 32'h0);
        settle();
        check("dh_n1_m_access", m_access, 0);
        tick();
        m_data = 32'hBEEF1234; m_ack = 1'b1;
        settle();
        check("dh_m_access", m_access, 1);
        check("dh_m_addr", m_addr, 32'h200);
        check("dh_m_bytesel", m_bytesel, 4'b1100);
        check("dh_m_wr_en", m_wr_en, 0);
        check("dh_g_compl", g_compl, 1);
        check("dh_g_error", g_error, 0);
        check("dh_g_rd_val", g_rd_val, 32'h0000BEEF);
        check("dh_c_ack", c_ack, 0);
        tick();
        m_ack = 1'b0;
        settle();
        check("dh_done_g_compl", g_compl, 0);
        check("dh_done_m_access", m_access, 0);

        // Debug byte write to lane 3
        dbg_pulse(32'h303, 2'b00, 1'b1, 32'h000000A5);
        tick();
        settle();
        check("dbw_m_addr", m_addr, 32'h300);
        check("dbw_m_bytesel", m_bytesel, 4'b1000);
        check("dbw_m_wr_val", m_wr_val, 32'hA5A5A5A5);
        check("dbw_m_wr_en", m_wr_en, 1);
        check("dbw_pre_g_compl", g_compl, 0);
        tick();
        m_ack = 1'b1;
        settle();
        check("dbw_g_compl", g_compl, 1);
        check("dbw_g_rd_val", g_rd_val, 32'h000000BE);
        tick();
        m_ack = 1'b0;
        settle();
        check("dbw_done_m_access", m_access, 0);

        // Debug pulse while a CPU transfer is on the bus
        c_access = 1'b1; c_addr = 32'h400; c_bytesel = 4'b0110; c_wr_en = 1'b1; c_wr_val = 32'h00ABCD00;
        tick();
        settle();
        check("ct_cpu_m_addr", m_addr, 32'h400);
        check("ct_cpu_m_wr_val", m_wr_val, 32'h00ABCD00);
        check("ct_cpu_m_bytesel", m_bytesel, 4'b0110);
        dbg_pulse(32'h500, 2'b10, 1'b0, 32'h0);
        m_ack = 1'b1;
        settle();
        check("ct_cpu_c_ack", c_ack, 1);
        check("ct_cpu_m_addr2", m_addr, 32'h400);
        tick();
        m_ack = 1'b0; c_access = 1'b0; c_wr_en = 1'b0;
        settle();
        check("ct_turnaround_m_access", m_access, 0);
        tick();
        m_data = 32'hCAFEF00D; m_ack = 1'b1;
        settle();
        check("ct_dbg_m_addr", m_addr, 32'h500);
        check("ct_dbg_m_bytesel", m_bytesel, 4'b1111);
        check("ct_dbg_g_rd_val", g_rd_val, 32'hCAFEF00D);
        check("ct_dbg_g_compl", g_compl, 1);
        tick();
        m_ack = 1'b0;
        settle();
        check("ct_dbg_done_m_access", m_access, 0);

        // CPU request and pending debug (width 11) in the same idle cycle
        dbg_pulse(32'h702, 2'b11, 1'b0, 32'h0);
        c_access = 1'b1; c_addr = 32'h600; c_bytesel = 4'b1111;
        settle();
        check("both_idle_m_access", m_access, 0);
        tick();
        settle();
        check("both_dbg_m_addr", m_addr, 32'h700);
        check("both_dbg_m_bytesel", m_bytesel, 4'b1111);
        check("both_dbg_c_ack", c_ack, 0);
        tick();
        m_data = 32'h87654321; m_ack = 1'b1;
        settle();
        check("both_dbg_g_compl", g_compl, 1);
        check("both_dbg_g_rd_val", g_rd_val, 32'h87654321);
        check("both_dbg_c_ack2", c_ack, 0);
        tick();
        m_ack = 1'b0;
        settle();
        check("both_turn_m_access", m_access, 0);
        check("both_turn_c_ack", c_ack, 0);
        tick();
        m_error = 1'b1;
        settle();
        check("both_cpu_m_addr", m_addr, 32'h600);
        check("both_cpu_c_error", c_error, 1);
        check("both_cpu_c_ack", c_ack, 0);
        tick();
        m_error = 1'b0; c_access = 1'b0;
        settle();
        check("both_cpu_done_m_access", m_access, 0);

        // Timeout with a silent slave: four bus cycles, then abort
        m_data = 32'hDEADBEEF;
        dbg_pulse(32'h800, 2'b10, 1'b0, 32'h0);
        tick();
        for (int i = 1; i <= 3; i++) begin
            settle();
            check($sformatf("to_c%0d_m_access", i), m_access, 1);
            check($sformatf("to_c%0d_g_compl", i), g_compl, 0);
            tick();
        end
        settle();
        check("to_c4_m_access", m_access, 1);
        check("to_c4_g_compl", g_compl, 1);
        check("to_c4_g_error", g_error, 1);
        check("to_c4_g_rd_val", g_rd_val, 0);
        tick();
        settle();
        check("to_done_m_access", m_access, 0);
        check("to_done_g_compl", g_compl, 0);

        // Ack arriving in the timeout cycle completes normally
        dbg_pulse(32'h804, 2'b10, 1'b0, 32'h0);
        tick();
        tick();
        tick();
        tick();
        m_ack = 1'b1;
        settle();
        check("toack_g_compl", g_compl, 1);
        check("toack_g_error", g_error, 0);
        check("toack_g_rd_val", g_rd_val, 32'hDEADBEEF);
        tick();
        m_ack = 1'b0;

        // Reset in the middle of a debug transfer
        dbg_pulse(32'h900, 2'b10, 1'b0, 32'h0);
        tick();
        settle();
        check("rstm_dbg_m_access", m_access, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0; m_ack = 1'b1;
        settle();
        check("rstm_m_access", m_access, 0);
        check("rstm_g_compl", g_compl, 0);
        tick();
        m_ack = 1'b0;
        settle();
        check("rstm_idle_m_access", m_access, 0);

        // Fresh debug byte read after the reset
        dbg_pulse(32'h901, 2'b00, 1'b0, 32'h0);
        tick();
        m_data = 32'h11223344; m_ack = 1'b1;
        settle();
        check("post_m_addr", m_addr, 32'h900);
        check("post_m_bytesel", m_bytesel, 4'b0010);
        check("post_g_compl", g_compl, 1);
        check("post_g_rd_val", g_rd_val, 32'h00000033);
        tick();
        m_ack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
